// File: rtl/input_debouncer_if.sv
// Signal bundle between the debouncer and whatever drives/observes it.
// The master side owns the raw input and the debug clear; the debouncer
// (slave side) owns the clean level and the observability outputs.
interface input_debouncer_if #(
  parameter int GLITCH_W = 4
) ();
  logic                a_raw;
  logic                clr_glitch;
  logic                a;
  logic                busy;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (
    output a_raw,
    output clr_glitch,
    input  a,
    input  busy,
    input  glitch_cnt
  );

  modport slave (
    input  a_raw,
    input  clr_glitch,
    output a,
    output busy,
    output glitch_cnt
  );
endinterface

// File: rtl/input_debouncer.sv
// Input debouncer: 2-flop synchronizer followed by a stability qualifier.
// The clean level only follows the synchronized input after it has held a
// new value for STABLE_CYCLES consecutive cycles. Aborted qualifications
// are counted in a saturating glitch counter for debug.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | cnt == 0, synchronized input agrees with the clean level
//   QUAL  | cnt  > 0, a candidate change is being qualified
module input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input_debouncer_if.slave bus
);

  // A 1-cycle qualifier still needs a 1-bit counter to keep the logic uniform.
  localparam int               CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic                s1, s2;
  logic                a_q, a_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [GLITCH_W-1:0] glitch_q, glitch_nxt;
  logic                mismatch;
  logic                reject;

  assign mismatch = (s2 != a_q);

  // Synchronizer, qualifier state and glitch counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      state    <= IDLE;
      a_q      <= 1'b0;
      cnt      <= '0;
      glitch_q <= '0;
    end else begin
      s1       <= bus.a_raw;
      s2       <= s1;
      state    <= state_nxt;
      a_q      <= a_nxt;
      cnt      <= cnt_nxt;
      glitch_q <= glitch_nxt;
    end
  end

  // Qualification: accept after CNT_MAX+1 mismatching cycles, reject if the
  // synchronized input falls back to the clean level before that.
  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    cnt_nxt   = cnt;
    reject    = 1'b0;
    if (mismatch) begin
      if (cnt == CNT_MAX) begin
        a_nxt     = s2;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end else begin
        cnt_nxt   = cnt + CNT_W'(1);
        state_nxt = QUAL;
      end
    end else begin
      case (state)
        QUAL: begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          reject    = 1'b1;
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Saturating glitch count; an explicit clear beats a coincident reject.
  always_comb begin
    glitch_nxt = glitch_q;
    if (bus.clr_glitch) begin
      glitch_nxt = '0;
    end else if (reject && (glitch_q != '1)) begin
      glitch_nxt = glitch_q + GLITCH_W'(1);
    end
  end

  assign bus.a          = a_q;
  assign bus.busy       = (cnt != '0);
  assign bus.glitch_cnt = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer (STABLE_CYCLES=4, GLITCH_W=4).
// Stimulus pushes every expected change of {a, busy, glitch_cnt} together
// with the cycle on which it must appear; the monitor pops one entry each
// time the observed tuple changes.
module tb_input_debouncer;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    int         at;
    logic       a;
    logic       busy;
    logic [3:0] g;
  } exp_t;

  exp_t       sb[$];
  logic       mon_en;
  logic [5:0] prev;
  logic       m_a;
  logic [3:0] m_g;

  input_debouncer_if #(.GLITCH_W(4)) dut_if ();

  input_debouncer #(
    .STABLE_CYCLES(4),
    .GLITCH_W     (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output tuple must match the next expectation.
  always @(posedge clk) begin
    logic [5:0] cur;
    exp_t       e;
    #1;
    if (mon_en) begin
      cur = {dut_if.a, dut_if.busy, dut_if.glitch_cnt};
      if (cur !== prev) begin
        if (sb.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_change cyc=%0d got a=%b busy=%b glitch=%0d",
                   cyc, cur[5], cur[4], cur[3:0]);
        end else begin
          e = sb.pop_front();
          checks = checks + 1;
          if (cur !== {e.a, e.busy, e.g}) begin
            errors = errors + 1;
            $display("FAIL tuple cyc=%0d got a=%b busy=%b glitch=%0d want a=%b busy=%b glitch=%0d",
                     cyc, cur[5], cur[4], cur[3:0], e.a, e.busy, e.g);
          end
          checks = checks + 1;
          if (cyc != e.at) begin
            errors = errors + 1;
            $display("FAIL timing got cyc=%0d want cyc=%0d", cyc, e.at);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expectation n posedges after the first posedge following the drive at base.
  task automatic expect_at(input int base, input int n, input logic a,
                           input logic busy, input logic [3:0] g);
    exp_t e;
    e.at   = base + 1 + n;
    e.a    = a;
    e.busy = busy;
    e.g    = g;
    sb.push_back(e);
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      errors = errors + 1;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step(input logic v);
    int base;
    base = cyc;
    dut_if.a_raw = v;
    expect_at(base, 2, m_a, 1'b1, m_g);
    expect_at(base, 5, v, 1'b0, m_g);
    m_a = v;
    tick(8);
  endtask

  task automatic clear_glitch();
    int base;
    base = cyc;
    dut_if.clr_glitch = 1'b1;
    if (m_g != 4'd0) expect_at(base, 0, m_a, 1'b0, 4'd0);
    tick(1);
    dut_if.clr_glitch = 1'b0;
    m_g = 4'd0;
    tick(2);
  endtask

  // One-cycle high pulse while a=0: busy blips, then a reject.
  task automatic glitch1();
    int         base;
    logic [3:0] ng;
    base = cyc;
    ng = (m_g == 4'd15) ? 4'd15 : m_g + 4'd1;
    expect_at(base, 2, 1'b0, 1'b1, m_g);
    expect_at(base, 3, 1'b0, 1'b0, ng);
    dut_if.a_raw = 1'b1;
    tick(1);
    dut_if.a_raw = 1'b0;
    tick(4);
    m_g = ng;
  endtask

  initial begin
    int base;
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    prev = '0;
    m_a = 1'b0;
    m_g = 4'd0;
    rst = 1'b1;
    dut_if.a_raw = 1'b1;
    dut_if.clr_glitch = 1'b0;

    // Reset held 3 cycles with a_raw high.
    tick(3);
    check_val("reset_a", int'(dut_if.a), 0);
    check_val("reset_busy", int'(dut_if.busy), 0);
    check_val("reset_glitch", int'(dut_if.glitch_cnt), 0);
    prev = 6'b0;
    mon_en = 1'b1;
    base = cyc;
    rst = 1'b0;
    expect_at(base, 2, 1'b0, 1'b1, 4'd0);
    expect_at(base, 5, 1'b1, 1'b0, 4'd0);
    m_a = 1'b1;
    tick(8);

    // Clean steps in both directions.
    step(1'b0);
    step(1'b1);
    step(1'b0);

    // 3-cycle pulse: rejected at posedge 5.
    base = cyc;
    expect_at(base, 2, 1'b0, 1'b1, 4'd0);
    expect_at(base, 5, 1'b0, 1'b0, 4'd1);
    dut_if.a_raw = 1'b1;
    tick(3);
    dut_if.a_raw = 1'b0;
    tick(6);
    m_g = 4'd1;

    // 4-cycle pulse: accepted at posedge 5, falls back four cycles after s2.
    base = cyc;
    expect_at(base, 2, 1'b0, 1'b1, 4'd1);
    expect_at(base, 5, 1'b1, 1'b0, 4'd1);
    expect_at(base, 6, 1'b1, 1'b1, 4'd1);
    expect_at(base, 9, 1'b0, 1'b0, 4'd1);
    dut_if.a_raw = 1'b1;
    tick(4);
    dut_if.a_raw = 1'b0;
    tick(9);

    // Saturation over 20 isolated glitches.
    clear_glitch();
    for (int i = 0; i < 20; i++) glitch1();
    check_val("saturated_glitch", int'(dut_if.glitch_cnt), 15);

    // Clear wins over a simultaneous reject at glitch_cnt=7.
    clear_glitch();
    for (int i = 0; i < 7; i++) glitch1();
    base = cyc;
    expect_at(base, 2, 1'b0, 1'b1, 4'd7);
    expect_at(base, 3, 1'b0, 1'b0, 4'd0);
    dut_if.a_raw = 1'b1;
    tick(1);
    dut_if.a_raw = 1'b0;
    tick(2);
    dut_if.clr_glitch = 1'b1;
    tick(1);
    dut_if.clr_glitch = 1'b0;
    m_g = 4'd0;
    tick(3);
    glitch1();

    // Reset while qualifying a rise with cnt=2.
    clear_glitch();
    base = cyc;
    expect_at(base, 2, 1'b0, 1'b1, 4'd0);
    expect_at(base, 4, 1'b0, 1'b0, 4'd0);
    dut_if.a_raw = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    base = cyc;
    rst = 1'b0;
    expect_at(base, 2, 1'b0, 1'b1, 4'd0);
    expect_at(base, 5, 1'b1, 1'b0, 4'd0);
    m_a = 1'b1;
    tick(8);
    check_val("post_reset_a", int'(dut_if.a), 1);
    step(1'b0);

    tick(5);
    check_val("pending_expectations", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Upstream conditioning stage for the edge and pulse detectors. It takes a raw, asynchronous, possibly bouncing input `a_raw` and passes it through a 2-flop synchronizer. It then produces a clean level `a` that changes only after the synchronized input has held a new value for `STABLE_CYCLES` consecutive cycles. `a` feeds the `a` input of the downstream detectors directly. A saturating glitch counter and a busy flag are provided for debug and observability.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive mismatching cycles required before `a` changes. Legal range ≥ 1.
- `GLITCH_W`, default 4: width of the glitch counter.

Ports:
- `clk`  input  1  single clock; all state updates on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `a_raw`  input  1  raw asynchronous input.
- `clr_glitch`  input  1  synchronous clear of `glitch_cnt`.
- `a`  output  1  debounced, synchronized level.
- `busy`  output  1  high while a candidate change is being qualified (`cnt != 0`).
- `glitch_cnt`  output  GLITCH_W  saturating count of rejected candidate changes.

## Operation
- Synchronizer:
  - `s1 <= a_raw`, then `s2 <= s1`.
  - Only `s2` is used by the logic below.
- Internal counter `cnt`:
  - Width is `$clog2(STABLE_CYCLES)`, minimum 1 bit.
  - `cnt` never exceeds `STABLE_CYCLES-1`.
- Two-state behaviour:
  - IDLE: `cnt == 0`, `s2 == a`.
  - QUAL: `cnt > 0`.
- Per cycle, when not in reset:
  - `s2 != a` and `cnt == STABLE_CYCLES-1`: `a <= s2`, `cnt <= 0`. This is the accept.
  - `s2 != a`, otherwise: `cnt <= cnt + 1`.
  - `s2 == a` and `cnt != 0`: `cnt <= 0` and `glitch_cnt` increments. This is the reject.
  - `s2 == a` and `cnt == 0`: hold.
- `STABLE_CYCLES == 1`: every mismatch is accepted on its first cycle, so `glitch_cnt` never increments.
- `glitch_cnt` saturates at `2**GLITCH_W - 1`. It never wraps.
- `clr_glitch`:
  - Sets `glitch_cnt <= 0`.
  - Wins over a simultaneous reject (result 0).
  - Has no effect on `a`, `cnt` or the synchronizer.
- `busy` is derived from the `cnt` register (`cnt != 0`). It has no combinational path from `a_raw`.
- Rising and falling changes are handled symmetrically. No edge outputs are produced here; edge detection belongs to the downstream stage.

## Timing
- Reset values (registered on the first posedge with `rst = 1`):
  - `s1 = s2 = 0`, `a = 0`, `cnt = 0`, `busy = 0`, `glitch_cnt = 0`.
- Reset mid-qualification: the pending change is dropped and no glitch is counted.
- Latency: if `a_raw` is sampled new at posedge k and held, `a` changes at posedge `k+1+STABLE_CYCLES`. With the default, that is 5 cycles after the first sample.
- Minimum accepted pulse width on `a_raw`: `STABLE_CYCLES` cycles. Any shorter excursion is rejected and counted.
- Reject timing: `glitch_cnt` updates on the posedge where `s2` first returns to `a`.
- `busy` timing:
  - Rises one posedge after the first mismatch is seen.
  - Falls on the accept or reject posedge.
- Bounce sequences:
  - A return to `a` during QUAL restarts qualification from 0 on the next mismatch.
  - Such restarts are counted individually in `glitch_cnt`.

## Test plan
Bench parameters: `STABLE_CYCLES=4`, `GLITCH_W=4`. Posedges are numbered from 0, where `a_raw` is first sampled.

- **Reset:** hold `rst` 3 cycles with `a_raw=1` → `a=0`, `busy=0`, `glitch_cnt=0`. Release `rst` → `a=1` at posedge 5 after release.
- **Clean step:** `a_raw` 0→1 sampled at posedge 0 and held →
  - `busy=1` after posedge 2.
  - `a=1` at posedge 5.
  - `busy=0` after posedge 5.
  - `glitch_cnt` stays 0.
  - Then 1→0 behaves symmetrically, with the same 5-cycle latency.
- **Pulse-width threshold:**
  - 3-cycle `a_raw` high pulse → `a` stays 0, `glitch_cnt=1` at posedge 5.
  - 4-cycle pulse → `a=1` at posedge 5. `a` returns to 0 four cycles after `s2` falls.
- **Saturation:** 20 isolated 1-cycle `a_raw` pulses → `glitch_cnt` ends at 15, not 4.
- **Clear priority:** assert `clr_glitch` on the same posedge as a reject with `glitch_cnt=7` → `glitch_cnt=0`. Then a further 1-cycle pulse → `glitch_cnt=1`.
- **Reset mid-operation:** assert `rst` for 1 cycle while `cnt=2` qualifying a rise → `a=0`, `busy=0`, `glitch_cnt` unchanged at 0. With `a_raw` still high, `a=1` at posedge 5 after `rst` falls.
